// File: rtl/cpu_pkg.sv
// Shared core definitions: instruction constants, FIFO occupancy states and the
// compressed-instruction test used by fetch and decode.
package cpu_pkg;

    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] INSTR_NOP = 32'h00000013;

    typedef enum logic [1:0] {
        FIFO_EMPTY   = 2'd0,
        FIFO_PARTIAL = 2'd1,
        FIFO_FULL    = 2'd2
    } fifo_state_e;

    // An all-zero word is the canonical illegal instruction, so it is never compact.
    function automatic logic is_compact(input logic [ILEN-1:0] instr);
        return (instr != '0) && (instr[1:0] != 2'b11);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Register-array FIFO with push, pop and flush; reports occupancy as a count and
// as an EMPTY/PARTIAL/FULL state. The head reads as zero when empty.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output fifo_state_e      state_o
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    always_comb begin
        push_ok  = push_i & ~flush_i & (count_q != FULL_CNT);
        pop_ok   = pop_i & ~flush_i & (count_q != '0);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; count gates every read, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_comb begin
        rdata_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
        count_o = count_q;
        if (count_q == '0)           state_o = FIFO_EMPTY;
        else if (count_q == FULL_CNT) state_o = FIFO_FULL;
        else                          state_o = FIFO_PARTIAL;
    end

endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch front-end: owns the fetch PC, issues same-cycle instruction reads and
// buffers {pc, instr, compact} entries for decode. Redirect flushes and retargets.
module instruction_fetch_queue
    import cpu_pkg::*;
#(
    parameter int              XLEN          = 32,
    parameter int              DEPTH         = 4,
    parameter logic [XLEN-1:0] RESET_PC      = '0,
    parameter bit              COMPRESSED_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [XLEN-1:0]        imem_addr,
    input  logic [ILEN-1:0]        imem_data,
    input  logic                   imem_success,
    input  logic                   redirect,
    input  logic [XLEN-1:0]        redirect_target,
    input  logic                   deq_ready,
    output logic                   deq_valid,
    output logic [ILEN-1:0]        deq_instr,
    output logic [XLEN-1:0]        deq_pc,
    output logic                   deq_compact,
    output logic [$clog2(DEPTH):0] count
);

    localparam int EW = XLEN + ILEN + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            push, pop, compact;
    logic [EW-1:0]   head;
    fifo_state_e     fifo_state;

    // Redirect outranks everything: it blocks the request, hides the head and retargets.
    always_comb begin
        imem_req   = ~rst & ~redirect & (fifo_state != FIFO_FULL);
        imem_addr  = fetch_pc_q;
        compact    = COMPRESSED_EN & is_compact(imem_data);
        push       = imem_req & imem_success;
        deq_valid  = (fifo_state != FIFO_EMPTY) & ~redirect;
        pop        = deq_valid & deq_ready;
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = {redirect_target[XLEN-1:1], 1'b0};
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + (compact ? XLEN'(2) : XLEN'(4));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fetch_pc_q <= RESET_PC;
        else     fetch_pc_q <= fetch_pc_d;
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect),
        .wdata_i ({fetch_pc_q, imem_data, compact}),
        .rdata_o (head),
        .count_o (count),
        .state_o (fifo_state)
    );

    assign {deq_pc, deq_instr, deq_compact} = head;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue; a second instance with compressed
// support disabled shares the stimulus to cover the fixed 4-byte stride.
module tb_instruction_fetch_queue;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] imem_data = 32'h0;
    logic        imem_success = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        deq_ready = 1'b0;

    logic        req_c, req_n;
    logic [31:0] addr_c, addr_n;
    logic        dv_c, dv_n;
    logic [31:0] di_c, di_n;
    logic [31:0] dpc_c, dpc_n;
    logic        dcp_c, dcp_n;
    logic [2:0]  cnt_c, cnt_n;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instruction_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0), .COMPRESSED_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .imem_req(req_c), .imem_addr(addr_c), .imem_data(imem_data),
        .imem_success(imem_success), .redirect(redirect), .redirect_target(redirect_target),
        .deq_ready(deq_ready), .deq_valid(dv_c), .deq_instr(di_c), .deq_pc(dpc_c),
        .deq_compact(dcp_c), .count(cnt_c)
    );

    instruction_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0), .COMPRESSED_EN(1'b0)) dut_nc (
        .clk(clk), .rst(rst), .imem_req(req_n), .imem_addr(addr_n), .imem_data(imem_data),
        .imem_success(imem_success), .redirect(redirect), .redirect_target(redirect_target),
        .deq_ready(deq_ready), .deq_valid(dv_n), .deq_instr(di_n), .deq_pc(dpc_n),
        .deq_compact(dcp_n), .count(cnt_n)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #2;
        chk("rst_req", 64'(req_c), 64'd0);
        chk("rst_addr", 64'(addr_c), 64'd0);
        chk("rst_valid", 64'(dv_c), 64'd0);
        chk("rst_pc", 64'(dpc_c), 64'd0);
        chk("rst_count", 64'(cnt_c), 64'd0);

        // Fill with deq_ready low
        @(posedge clk); #1;
        rst = 1'b0;
        imem_success = 1'b1;
        imem_data = INSTR_NOP;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("fill_req", 64'(req_c), 64'd1);
            chk("fill_addr", 64'(addr_c), 64'(4 * i));
            chk("fill_count", 64'(cnt_c), 64'(i));
            tick();
        end
        chk("full_count", 64'(cnt_c), 64'd4);
        chk("full_req", 64'(req_c), 64'd0);
        chk("full_valid", 64'(dv_c), 64'd1);
        chk("full_pc", 64'(dpc_c), 64'd0);
        chk("full_instr", 64'(di_c), 64'h13);
        tick();
        chk("hold_count", 64'(cnt_c), 64'd4);
        chk("hold_pc", 64'(dpc_c), 64'd0);
        chk("hold_addr", 64'(addr_c), 64'd16);

        // Redirect on a full FIFO with decode ready
        redirect = 1'b1;
        redirect_target = 32'h101;
        deq_ready = 1'b1;
        #1;
        chk("redir_valid", 64'(dv_c), 64'd0);
        chk("redir_req", 64'(req_c), 64'd0);
        tick();
        chk("redir_count", 64'(cnt_c), 64'd0);
        chk("redir_addr", 64'(addr_c), 64'h100);
        chk("redir_valid2", 64'(dv_c), 64'd0);
        redirect = 1'b0;
        #1;
        chk("redir_req2", 64'(req_c), 64'd1);
        tick();
        chk("redir_head", 64'(dpc_c), 64'h100);
        chk("redir_hvalid", 64'(dv_c), 64'd1);
        chk("redir_hcount", 64'(cnt_c), 64'd1);

        // Steady stream: one per cycle, pointers wrap past DEPTH
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("steady_pc", 64'(dpc_c), 64'(32'h100 + 4 * k));
            chk("steady_count", 64'(cnt_c), 64'd1);
        end

        // Compact detection and stride
        redirect = 1'b1;
        redirect_target = 32'h0;
        deq_ready = 1'b0;
        tick();
        redirect = 1'b0;
        #1;
        chk("cmp_addr0", 64'(addr_c), 64'd0);
        tick();
        imem_data = 32'h00004501;
        #1;
        chk("cmp_pc0", 64'(dpc_c), 64'd0);
        chk("cmp_c0", 64'(dcp_c), 64'd0);
        chk("cmp_addr4", 64'(addr_c), 64'd4);
        tick();
        chk("cmp_next_c", 64'(addr_c), 64'd6);
        chk("cmp_next_nc", 64'(addr_n), 64'd8);
        chk("cmp_count", 64'(cnt_c), 64'd2);
        deq_ready = 1'b1;
        imem_success = 1'b0;
        tick();
        chk("cmp_pc4", 64'(dpc_c), 64'd4);
        chk("cmp_c4", 64'(dcp_c), 64'd1);
        chk("cmp_i4", 64'(di_c), 64'h4501);
        chk("cmp_c4_nc", 64'(dcp_n), 64'd0);
        deq_ready = 1'b0;

        // Memory wait-states
        for (int w = 0; w < 3; w++) begin
            #1;
            chk("wait_addr_c", 64'(addr_c), 64'd6);
            chk("wait_addr_nc", 64'(addr_n), 64'd8);
            chk("wait_req", 64'(req_n), 64'd1);
            chk("wait_count", 64'(cnt_n), 64'd1);
            tick();
        end
        imem_success = 1'b1;
        imem_data = INSTR_NOP;
        tick();
        chk("ws_addr_nc", 64'(addr_n), 64'd12);
        chk("ws_addr_c", 64'(addr_c), 64'd10);
        chk("ws_count", 64'(cnt_n), 64'd2);
        deq_ready = 1'b1;
        imem_success = 1'b0;
        tick();
        chk("ws_pc_nc", 64'(dpc_n), 64'd8);
        chk("ws_pc_c", 64'(dpc_c), 64'd6);
        chk("ws_count2", 64'(cnt_n), 64'd1);

        // Asynchronous reset between edges
        imem_success = 1'b1;
        tick();
        tick();
        #3;
        rst = 1'b1;
        #1;
        chk("arst_req", 64'(req_c), 64'd0);
        chk("arst_addr", 64'(addr_c), 64'd0);
        chk("arst_valid", 64'(dv_c), 64'd0);
        chk("arst_pc", 64'(dpc_c), 64'd0);
        chk("arst_instr", 64'(di_c), 64'd0);
        chk("arst_cmp", 64'(dcp_c), 64'd0);
        chk("arst_count", 64'(cnt_c), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("post_addr", 64'(addr_c), 64'd0);
        chk("post_req", 64'(req_c), 64'd1);
        tick();
        chk("post_head", 64'(dpc_c), 64'd0);
        chk("post_count", 64'(cnt_c), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
